clk_div_prog: RTL and testbench

Multi-channel, runtime-programmable clock divider. It is the successor to the fixed single-output divider. Each channel produces a divided clock with programmable period and duty cycle, plus a period-start tick. Configuration arrives over a valid/ready write port. New settings take effect only at a period boundary, so outputs never glitch or produce runt pulses. It sits beside the system clock source and feeds slow peripheral clocks and clock-enables.

---
 rtl/clk_div_prog.sv | 163 ++++++++++++++++
 tb/tb_clk_div_prog.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider with per-channel period/duty
// and a period-start tick. Define CLKDIV_RDBK_EN to add the active-config readback port.
module clk_div_prog #(
    parameter int CLK_IN_FREQ = 1_000_000,
    parameter int TGT_FREQ    = 1_000,
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_err,
`ifdef CLKDIV_RDBK_EN
    input  logic [CH_W-1:0]   rd_ch,
    output logic [CNT_W-1:0]  rd_div,
    output logic [CNT_W-1:0]  rd_high,
    output logic              rd_pend,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam int              DEF_DIV    = CLK_IN_FREQ / TGT_FREQ;
    localparam logic [CNT_W-1:0] DEF_DIV_V  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_HIGH_V = CNT_W'(DEF_DIV / 2);
    localparam logic [CH_W:0]    NUM_CH_V   = (CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] cfg_sel;
    logic [NUM_CH-1:0] wr_en;
    logic              ch_ok;
    logic              cfg_bad;
    logic              cfg_xfer;
    logic [CNT_W-1:0]  cfg_high_eff;

    // Decode through a compare loop so a non-power-of-two NUM_CH never indexes past the vector.
    always_comb begin
        cfg_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cfg_sel[i] = ({1'b0, cfg_ch} == (CH_W + 1)'(i));
        end
    end

    always_comb begin
        ch_ok        = ({1'b0, cfg_ch} < NUM_CH_V);
        cfg_ready    = ch_ok ? ~|(pending & cfg_sel) : 1'b1;
        cfg_xfer     = cfg_valid & cfg_ready;
        cfg_bad      = !ch_ok || (cfg_div < CNT_W'(2)) || (cfg_high >= cfg_div);
        wr_en        = (cfg_xfer && !cfg_bad) ? cfg_sel : '0;
        cfg_high_eff = (cfg_high == '0) ? (cfg_div >> 1) : cfg_high;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_xfer & cfg_bad;
        end
    end

`ifdef CLKDIV_RDBK_EN
    logic [CNT_W-1:0] div_vec  [NUM_CH];
    logic [CNT_W-1:0] high_vec [NUM_CH];
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] high_act;
        logic [CNT_W-1:0] sh_div;
        logic [CNT_W-1:0] sh_high;
        logic             pend;
        logic             clk_r;
        logic             tick_r;
        logic             wrap;

        assign cnt_nxt = cnt + CNT_W'(1);
        assign wrap    = (cnt == div_act - CNT_W'(1));

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt      <= DEF_DIV_V - CNT_W'(1);
                div_act  <= DEF_DIV_V;
                high_act <= DEF_HIGH_V;
                sh_div   <= DEF_DIV_V;
                sh_high  <= DEF_HIGH_V;
                pend     <= 1'b0;
                clk_r    <= 1'b0;
                tick_r   <= 1'b0;
            end else begin
                if (wr_en[i]) begin
                    sh_div  <= cfg_div;
                    sh_high <= cfg_high_eff;
                end

                if (!ch_en[i]) begin
                    // Park one short of the wrap so the first enabled edge starts a fresh period.
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                    if (pend) begin
                        div_act  <= sh_div;
                        high_act <= sh_high;
                        cnt      <= sh_div - CNT_W'(1);
                        pend     <= 1'b0;
                    end else begin
                        cnt <= div_act - CNT_W'(1);
                    end
                end else if (wrap) begin
                    // Active high time is never zero, so a period always opens high.
                    cnt    <= '0;
                    tick_r <= 1'b1;
                    clk_r  <= 1'b1;
                    if (pend) begin
                        div_act  <= sh_div;
                        high_act <= sh_high;
                        pend     <= 1'b0;
                    end
                end else begin
                    cnt    <= cnt_nxt;
                    tick_r <= 1'b0;
                    clk_r  <= (cnt_nxt < high_act);
                end

                // A write is only accepted while pend is clear, so this never races the apply.
                if (wr_en[i]) begin
                    pend <= 1'b1;
                end
            end
        end

        assign clk_out[i] = clk_r;
        assign tick[i]    = tick_r;
        assign pending[i] = pend;

`ifdef CLKDIV_RDBK_EN
        assign div_vec[i]  = div_act;
        assign high_vec[i] = high_act;
`endif
    end

`ifdef CLKDIV_RDBK_EN
    always_comb begin
        rd_div  = '0;
        rd_high = '0;
        rd_pend = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if ({1'b0, rd_ch} == (CH_W + 1)'(i)) begin
                rd_div  = div_vec[i];
                rd_high = high_vec[i];
                rd_pend = pending[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed scenarios then random traffic, checked against a
// time-elapsed reference model; a second 5-channel instance covers out-of-range channels.
module tb_clk_div_prog;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  ch_en = '0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_div = '0;
    logic [15:0] cfg_high = '0;
    logic        cfg_ready;
    logic        cfg_err;
    logic [3:0]  clk_out;
    logic [3:0]  tick;

    logic [4:0]  b_en = '0;
    logic        b_valid = 1'b0;
    logic [2:0]  b_ch = '0;
    logic [15:0] b_div = '0;
    logic [15:0] b_high = '0;
    logic        b_ready;
    logic        b_err;
    logic [4:0]  b_clk;
    logic [4:0]  b_tick;

`ifdef CLKDIV_RDBK_EN
    logic [1:0]  rd_ch = '0;
    logic [15:0] rd_div;
    logic [15:0] rd_high;
    logic        rd_pend;
    logic [2:0]  b_rd_ch = '0;
    logic [15:0] b_rd_div;
    logic [15:0] b_rd_high;
    logic        b_rd_pend;
`endif

    always #5 clk = ~clk;

    clk_div_prog #(.CLK_IN_FREQ(1000), .TGT_FREQ(100), .NUM_CH(4), .CNT_W(16)) u_dut (
        .clk_in(clk), .rst_n(rst_n), .ch_en(ch_en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_err(cfg_err),
`ifdef CLKDIV_RDBK_EN
        .rd_ch(rd_ch), .rd_div(rd_div), .rd_high(rd_high), .rd_pend(rd_pend),
`endif
        .clk_out(clk_out), .tick(tick)
    );

    clk_div_prog #(.CLK_IN_FREQ(1000), .TGT_FREQ(100), .NUM_CH(5), .CNT_W(16)) u_dut5 (
        .clk_in(clk), .rst_n(rst_n), .ch_en(b_en),
        .cfg_valid(b_valid), .cfg_ready(b_ready), .cfg_ch(b_ch),
        .cfg_div(b_div), .cfg_high(b_high), .cfg_err(b_err),
`ifdef CLKDIV_RDBK_EN
        .rd_ch(b_rd_ch), .rd_div(b_rd_div), .rd_high(b_rd_high), .rd_pend(b_rd_pend),
`endif
        .clk_out(b_clk), .tick(b_tick)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: each running channel remembers the cycle its period began.
    int   m_div   [4];
    int   m_high  [4];
    int   m_start [4];
    int   m_sdiv  [4];
    int   m_shigh [4];
    bit   m_run   [4];
    bit   m_pend  [4];
    logic [3:0] e_clk;
    logic [3:0] e_tick;
    logic       e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_div[i]  = 10;
            m_high[i] = 5;
            m_run[i]  = 1'b0;
            m_pend[i] = 1'b0;
        end
        e_clk  = '0;
        e_tick = '0;
        e_err  = 1'b0;
    endtask

    task automatic check_quiet();
        check("rst_clk_out", clk_out, 0);
        check("rst_tick", tick, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_cfg_ready", cfg_ready, 1);
    endtask

    task automatic do_reset(input int ncyc);
        cfg_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_quiet();
        repeat (ncyc) begin
            @(negedge clk);
            check_quiet();
        end
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [3:0] en, input logic v, input logic [1:0] ch,
                        input int div, input int high);
        bit rdy;
        int pos;
        ch_en     = en;
        cfg_valid = v;
        cfg_ch    = ch;
        cfg_div   = 16'(div);
        cfg_high  = 16'(high);
`ifdef CLKDIV_RDBK_EN
        rd_ch = 2'($urandom_range(0, 3));
`endif
        #1;
        rdy = !m_pend[ch];
        check("cfg_ready", cfg_ready, rdy);
`ifdef CLKDIV_RDBK_EN
        check("rd_div", rd_div, m_div[rd_ch]);
        check("rd_high", rd_high, m_high[rd_ch]);
        check("rd_pend", rd_pend, m_pend[rd_ch]);
`endif
        for (int i = 0; i < 4; i++) begin
            if (!en[i]) begin
                m_run[i] = 1'b0;
                if (m_pend[i]) begin
                    m_div[i]  = m_sdiv[i];
                    m_high[i] = m_shigh[i];
                    m_pend[i] = 1'b0;
                end
                e_clk[i]  = 1'b0;
                e_tick[i] = 1'b0;
            end else begin
                if (!m_run[i] || (cyc - m_start[i] == m_div[i])) begin
                    if (m_pend[i]) begin
                        m_div[i]  = m_sdiv[i];
                        m_high[i] = m_shigh[i];
                        m_pend[i] = 1'b0;
                    end
                    m_start[i] = cyc;
                    m_run[i]   = 1'b1;
                end
                pos = cyc - m_start[i];
                e_tick[i] = (pos == 0);
                e_clk[i]  = (pos < m_high[i]);
            end
        end
        e_err = 1'b0;
        if (v && rdy) begin
            if (div < 2 || high >= div) begin
                e_err = 1'b1;
            end else begin
                m_sdiv[ch]  = div;
                m_shigh[ch] = (high == 0) ? div / 2 : high;
                m_pend[ch]  = 1'b1;
            end
        end
        cyc++;
        @(negedge clk);
        check("clk_out", clk_out, e_clk);
        check("tick", tick, e_tick);
        check("cfg_err", cfg_err, e_err);
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'hF, 1'b0, 2'd0, 0, 0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2;
        do_reset(3);
    endtask

    task automatic b_write(input logic [2:0] ch, input int div, input int high,
                           input logic exp_rdy, input logic exp_err);
        b_valid = 1'b1;
        b_ch    = ch;
        b_div   = 16'(div);
        b_high  = 16'(high);
        #1;
        check("b_cfg_ready", b_ready, exp_rdy);
        @(negedge clk);
        check("b_cfg_err", b_err, exp_err);
        check("b_clk_out", b_clk, 0);
        b_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] ren;
        int         d;
        #2;
        do_reset(3);

        idle(25);

        step(4'hF, 1'b1, 2'd1, 7, 0);
        idle(3);
        step(4'hF, 1'b1, 2'd1, 3, 0);
        idle(26);

        step(4'hF, 1'b1, 2'd0, 1, 0);
        idle(3);
        step(4'hF, 1'b1, 2'd3, 8, 8);
        idle(3);

        step(4'hF, 1'b1, 2'd2, 4, 1);
        repeat (4) step(4'hB, 1'b0, 2'd0, 0, 0);
        idle(16);

        step(4'hF, 1'b1, 2'd0, 2, 1);
        idle(12);
        mid_reset();
        idle(25);

        ren = 4'hF;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) ren[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 399) == 0) begin
                mid_reset();
                ren = 4'hF;
            end
            d = $urandom_range(0, 12);
            step(ren, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                 d, $urandom_range(0, d + 1));
        end

        @(negedge clk);
        b_write(3'd5, 4, 1, 1'b1, 1'b1);
        b_write(3'd7, 4, 0, 1'b1, 1'b1);
        b_write(3'd4, 6, 2, 1'b1, 1'b0);
        b_write(3'd4, 3, 9, 1'b0, 1'b0);
        b_write(3'd4, 3, 9, 1'b1, 1'b1);
`ifdef CLKDIV_RDBK_EN
        b_rd_ch = 3'd4;
        #1;
        check("b_rd_div", b_rd_div, 6);
        check("b_rd_high", b_rd_high, 2);
        check("b_rd_pend", b_rd_pend, 0);
        b_rd_ch = 3'd6;
        #1;
        check("b_rd_div_oob", b_rd_div, 0);
        check("b_rd_high_oob", b_rd_high, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
